// File: rtl/rom_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_stream_reader
//  Description : Burst-read controller for a synchronous ROM. A start pulse
//                launches a run of consecutive ROM reads; every returned byte
//                is captured and offered on a valid/ready stream, one byte
//                per handshake, and a done pulse closes the burst.
//                Optional running checksum enabled by ROM_STREAM_CHECKSUM_EN.
//  Revision    : 1.0  initial release
// ============================================================================

module rom_stream_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rom_cs,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready
`ifdef ROM_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    // Full ROM depth, used when count is given as 0.
    localparam logic [ADDR_W:0]   c_DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_REM_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_OUTPUT  = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_busy;
    logic              r_done;
    logic              r_rom_cs;
    logic              r_rom_rd;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_checksum;

    logic              w_handshake;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_last_byte;

    assign w_handshake = r_out_valid & out_ready;
    assign w_next_addr = r_cur_addr + c_ADDR_ONE;   // wraps at 2**ADDR_W
    assign w_last_byte = (r_remaining == c_REM_ONE);

    // Burst sequencer: every output is a register so that an async reset
    // drops the ROM strobes and the stream in the same instant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rom_cs    <= 1'b0;
            r_rom_rd    <= 1'b0;
            r_rom_addr  <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_checksum  <= '0;
        end else begin
            // done is a single-cycle pulse unless re-armed below
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur_addr  <= start_addr;
                        r_remaining <= (count == '0) ? c_DEPTH : count;
                        r_busy      <= 1'b1;
                        // strobes go up together with the ISSUE state
                        r_rom_cs    <= 1'b1;
                        r_rom_rd    <= 1'b1;
                        r_rom_addr  <= start_addr;
                        r_checksum  <= '0;
                        r_state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // ROM registers its byte at the end of this cycle
                    r_state <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    // strobes were held this cycle so rom_data is driven here
                    r_out_data  <= rom_data;
                    r_out_addr  <= r_cur_addr;
                    r_out_valid <= 1'b1;
                    r_rom_cs    <= 1'b0;
                    r_rom_rd    <= 1'b0;
                    r_state     <= S_OUTPUT;
                end

                S_OUTPUT: begin
                    if (w_handshake) begin
                        r_out_valid <= 1'b0;
                        r_remaining <= r_remaining - c_REM_ONE;
                        r_cur_addr  <= w_next_addr;
                        r_checksum  <= r_checksum + r_out_data;
                        if (w_last_byte) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_rom_cs   <= 1'b1;
                            r_rom_rd   <= 1'b1;
                            r_rom_addr <= w_next_addr;
                            r_state    <= S_ISSUE;
                        end
                    end
                end

                S_FINISH: begin
                    // start is deliberately not looked at here
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_rom_cs    <= 1'b0;
                    r_rom_rd    <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rom_cs    = r_rom_cs;
    assign rom_rd    = r_rom_rd;
    assign rom_addr  = r_rom_addr;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_valid = r_out_valid;

`ifdef ROM_STREAM_CHECKSUM_EN
    assign checksum = r_checksum;
`else
    // Without the checksum port the accumulator has no observer.
    logic w_checksum_unused;
    assign w_checksum_unused = ^r_checksum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_stream_reader
//  Description : Self-checking bench for rom_stream_reader with a registered
//                ROM model, directed bursts and randomized bursts checked
//                against an address/data list derived from the burst rules.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_rom_stream_reader;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] count;
    logic       out_ready;
    logic       busy, done, rom_cs, rom_rd, out_valid;
    logic [3:0] rom_addr, out_addr;
    logic [7:0] out_data;
    wire  [7:0] rom_data;
`ifdef ROM_STREAM_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [7:0] rom_img [0:15] = '{8'h0A, 8'h28, 8'h1E, 8'h28, 8'h32, 8'h3C, 8'h46, 8'h50,
                                   8'h5A, 8'h64, 8'h6E, 8'h78, 8'h82, 8'h8C, 8'h96, 8'hA0};
    logic [7:0] rom_q = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    rom_stream_reader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .rom_cs     (rom_cs),
        .rom_rd     (rom_rd),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef ROM_STREAM_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous ROM: registered read, tri-stated when not selected
    always @(posedge clk) if (rom_cs && rom_rd) rom_q <= rom_img[rom_addr];
    assign rom_data = rom_cs ? rom_q : 8'hzz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One burst: ready_pct = chance of accepting per cycle, optional stall of
    // stall_len cycles on byte stall_idx, optional stray start at cycle poke_at,
    // optional start pulse during the FINISH cycle.
    task automatic run_burst(input logic [3:0] sa, input logic [4:0] cnt, input int ready_pct,
                             input int stall_idx, input int stall_len, input int poke_at,
                             input bit finish_poke);
        int         n;
        int         idx;
        int         cyc;
        int         stall_left;
        int         last_seen;
        bit         seen_this;
        logic [7:0] exp_d [$];
        logic [3:0] exp_a [$];
        logic [7:0] sum;
        logic [7:0] held_d;
        logic [3:0] held_a;

        n = (cnt == 0) ? DEPTH : int'(cnt);
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(4'((int'(sa) + i) % DEPTH));
            exp_d.push_back(rom_img[(int'(sa) + i) % DEPTH]);
        end
        sum = 8'h00;

        @(negedge clk);
        start = 1'b1; start_addr = sa; count = cnt; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; start_addr = 4'($urandom); count = 5'($urandom);
        check("busy_issue", busy, 1);
        check("valid_issue", out_valid, 0);
`ifdef ROM_STREAM_CHECKSUM_EN
        check("checksum_cleared", checksum, 0);
`endif
        @(negedge clk);
        check("valid_capture", out_valid, 0);
        check("cs_capture", rom_cs, 1);
        @(negedge clk);
        check("first_valid_latency", out_valid, 1);

        idx = 0; cyc = 0; seen_this = 0; stall_left = stall_len; last_seen = -1;
        held_d = 8'h00; held_a = 4'h0;
        while (idx < n) begin
            if (cyc >= 2000) begin
                check("burst_timeout", idx, n);
                break;
            end
            check("busy_in_burst", busy, 1);
            check("no_early_done", done, 0);
            if (out_valid) begin
                if (!seen_this) begin
                    check("byte_data", out_data, exp_d[idx]);
                    check("byte_addr", out_addr, exp_a[idx]);
                    if (ready_pct == 100 && stall_len == 0 && last_seen >= 0)
                        check("byte_spacing", cyc - last_seen, 3);
                    last_seen = cyc;
                    held_d = out_data;
                    held_a = out_addr;
                    seen_this = 1;
                end else begin
                    check("stall_data_stable", out_data, held_d);
                    check("stall_addr_stable", out_addr, held_a);
                end
                check("cs_low_in_output", rom_cs, 0);
                if (idx == stall_idx && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = ($urandom_range(99) < ready_pct);
                end
                if (out_ready) begin
                    sum = sum + out_data;
                    idx++;
                    seen_this = 0;
                end
            end else begin
                out_ready = 1'($urandom_range(1));
            end
            if (cyc == poke_at) begin
                start = 1'b1; start_addr = 4'($urandom); count = 5'($urandom_range(16));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;

        check("done_pulse", done, 1);
        check("busy_finish", busy, 0);
        check("valid_finish", out_valid, 0);
`ifdef ROM_STREAM_CHECKSUM_EN
        check("checksum_value", checksum, sum);
`endif
        if (finish_poke) begin
            start = 1'b1; start_addr = 4'h9; count = 5'd2;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_single", done, 0);
        check("idle_busy", busy, 0);
        @(negedge clk);
        check("finish_start_ignored", busy, 0);
`ifdef ROM_STREAM_CHECKSUM_EN
        check("checksum_stable", checksum, sum);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = 4'h0; count = 5'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs", rom_cs, 0);
        check("rst_rd", rom_rd, 0);
        check("rst_valid", out_valid, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic burst, with a start pulse during FINISH
        run_burst(4'd0, 5'd4, 100, -1, 0, -1, 1'b1);
        // Address wrap
        run_burst(4'd14, 5'd3, 100, -1, 0, -1, 1'b0);
        // count of 0 reads the whole ROM
        run_burst(4'd5, 5'd0, 100, -1, 0, -1, 1'b0);
        // Seven-cycle stall on the second byte
        run_burst(4'd0, 5'd4, 100, 1, 7, -1, 1'b0);
        // Stray start in the middle of a burst
        run_burst(4'd2, 5'd6, 100, -1, 0, 4, 1'b0);

        // Reset while in CAPTURE
        @(negedge clk);
        start = 1'b1; start_addr = 4'd3; count = 5'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_cs", rom_cs, 1);
        rst = 1'b1;
        #1;
        check("arst_cs", rom_cs, 0);
        check("arst_rd", rom_rd, 0);
        check("arst_busy", busy, 0);
        check("arst_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_addr", out_addr, 0);
        check("arst_rom_addr", rom_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_done", done, 0);
            check("post_rst_idle", busy, 0);
        end
        run_burst(4'd7, 5'd2, 100, -1, 0, -1, 1'b0);

        // Randomized bursts with random backpressure
        for (int k = 0; k < 8; k++) begin
            run_burst(4'($urandom), 5'($urandom_range(16)), int'($urandom_range(30, 100)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 12)), 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
